// File: rtl/scr1_tb_ahb_pkg.sv
// Shared types and AHB encodings for the SCR1 testbench AHB slave memory model.
// HTRANS/HSIZE values match scr1_ahb.svh.
package scr1_tb_ahb_pkg;

   typedef enum logic [1:0] {
      WMODE_NONE   = 2'd0,
      WMODE_FIXED  = 2'd1,
      WMODE_RANDOM = 2'd2,
      WMODE_RSVD   = 2'd3
   } wait_mode_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } ahb_state_e;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_8  = 3'b000;
   localparam logic [2:0] HSIZE_16 = 3'b001;
   localparam logic [2:0] HSIZE_32 = 3'b010;
   localparam logic [2:0] HSIZE_64 = 3'b011;

endpackage

// File: rtl/scr1_tb_lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11 (state bits 15,13,12,10), shifting toward the MSB.
module scr1_tb_lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        adv,
   output logic [15:0] state
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SEED;
      end else if (adv) begin
         state <= {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
      end
   end

endmodule

// File: rtl/scr1_tb_ahb_slave_mem.sv
// AHB-Lite slave memory model with configurable wait states, error window and byte-lane writes.
// The storage array mem is preloaded by the bench through hierarchical access.
module scr1_tb_ahb_slave_mem
   import scr1_tb_ahb_pkg::*;
#(
   parameter int          DATA_W    = 32,
   parameter int          ADDR_W    = 32,
   parameter int          MEM_BYTES = 1048576,
   parameter int          WAIT_W    = 4,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        cfg_mode,
   input  logic [WAIT_W-1:0] cfg_wait,
   input  logic              cfg_err_en,
   input  logic [ADDR_W-1:0] cfg_err_lo,
   input  logic [ADDR_W-1:0] cfg_err_hi,
   input  logic [1:0]        htrans,
   input  logic [2:0]        hsize,
   input  logic [ADDR_W-1:0] haddr,
   input  logic              hwrite,
   input  logic [DATA_W-1:0] hwdata,
   output logic              hready,
   output logic              hresp,
   output logic [DATA_W-1:0] hrdata,
   output logic [15:0]       err_cnt
);

   localparam int BYTES     = DATA_W / 8;
   localparam int LANE_BITS = $clog2(BYTES);
   localparam int AQ_W      = $clog2(MEM_BYTES);
   localparam int MEM_WORDS = MEM_BYTES / BYTES;

   logic [DATA_W-1:0] mem [MEM_WORDS];

   ahb_state_e        state, state_nxt;
   logic [WAIT_W-1:0] wcnt_q, wcnt_nxt;
   logic [AQ_W-1:0]   addr_q;
   logic [2:0]        size_q;
   logic              write_q;
   logic              err_q;

   logic              accept;
   logic              acc_err;
   logic [WAIT_W-1:0] acc_wait;
   logic [15:0]       lfsr;
   logic [BYTES-1:0]  byte_en;
   logic [AQ_W-LANE_BITS-1:0] word_idx;
   logic              unused_bits;

   function automatic logic is_error(input logic [ADDR_W-1:0] a, input logic [2:0] sz,
                                     input logic en, input logic [ADDR_W-1:0] lo,
                                     input logic [ADDR_W-1:0] hi);
      logic [7:0] amask;
      logic       oob, mis, big, win;
      amask = 8'((9'd1 << sz) - 9'd1);
      oob   = {1'b0, a} >= (ADDR_W+1)'(MEM_BYTES);
      mis   = |(a[7:0] & amask);
      big   = sz > 3'(LANE_BITS);
      win   = en && (a >= lo) && (a <= hi);
      return oob | mis | big | win;
   endfunction

   function automatic logic [BYTES-1:0] lane_mask(input logic [LANE_BITS-1:0] off,
                                                  input logic [2:0] sz);
      logic [BYTES-1:0] m;
      m = '0;
      for (int b = 0; b < BYTES; b++)
         m[b] = (b >= int'(off)) && (b < int'(off) + (1 << sz));
      return m;
   endfunction

   scr1_tb_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .adv   (accept),
      .state (lfsr)
   );

   assign unused_bits = ^{lfsr[15:WAIT_W], htrans[0]};

   assign accept  = htrans[1] & hready;
   assign acc_err = is_error(haddr, hsize, cfg_err_en, cfg_err_lo, cfg_err_hi);

   always_comb begin
      case (wait_mode_e'(cfg_mode))
         WMODE_FIXED:  acc_wait = cfg_wait;
         WMODE_RANDOM: acc_wait = lfsr[WAIT_W-1:0] & cfg_wait;
         default:      acc_wait = '0;
      endcase
   end

   always_comb begin
      hready = 1'b1;
      hresp  = 1'b0;
      case (state)
         ST_WAIT: hready = 1'b0;
         ST_ERR1: begin
            hready = 1'b0;
            hresp  = 1'b1;
         end
         ST_ERR2: hresp = 1'b1;
         default: ;
      endcase
   end

   // Waits always precede the response phase, including the two-cycle ERROR response
   always_comb begin
      state_nxt = state;
      wcnt_nxt  = wcnt_q;
      case (state)
         ST_WAIT: begin
            wcnt_nxt = wcnt_q - WAIT_W'(1);
            if (wcnt_q == WAIT_W'(1))
               state_nxt = err_q ? ST_ERR1 : ST_DATA;
         end
         ST_ERR1: state_nxt = ST_ERR2;
         default: state_nxt = ST_IDLE;
      endcase
      if (accept) begin
         wcnt_nxt  = acc_wait;
         state_nxt = (acc_wait != '0) ? ST_WAIT : (acc_err ? ST_ERR1 : ST_DATA);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         wcnt_q  <= '0;
         err_cnt <= '0;
      end else begin
         state  <= state_nxt;
         wcnt_q <= wcnt_nxt;
         if (state == ST_ERR2 && err_cnt != 16'hFFFF)
            err_cnt <= err_cnt + 16'd1;
      end
   end

   // Upper address bits only matter for classification, so only in-range bits are kept
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q  <= haddr[AQ_W-1:0];
         size_q  <= hsize;
         write_q <= hwrite;
         err_q   <= acc_err;
      end
   end

   assign word_idx = addr_q[AQ_W-1:LANE_BITS];
   assign byte_en  = lane_mask(addr_q[LANE_BITS-1:0], size_q);

   always_ff @(posedge clk) begin
      if (state == ST_DATA && write_q) begin
         for (int b = 0; b < BYTES; b++)
            if (byte_en[b]) mem[word_idx][8*b +: 8] <= hwdata[8*b +: 8];
      end
   end

   assign hrdata = (state == ST_DATA) ? mem[word_idx] : '0;

endmodule

// File: tb/tb_scr1_tb_ahb_slave_mem.sv
// Bench for scr1_tb_ahb_slave_mem: directed transfers plus a per-cycle response model.
module tb_scr1_tb_ahb_slave_mem;

   localparam int MEM_BYTES = 65536;
   localparam int MEM_WORDS = MEM_BYTES / 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  cfg_mode = 2'd0;
   logic [3:0]  cfg_wait = 4'd0;
   logic        cfg_err_en = 1'b0;
   logic [31:0] cfg_err_lo = 32'h1000;
   logic [31:0] cfg_err_hi = 32'h10FF;
   logic [1:0]  htrans = 2'b00;
   logic [2:0]  hsize = 3'd2;
   logic [31:0] haddr = 32'd0;
   logic        hwrite = 1'b0;
   logic [31:0] hwdata = 32'd0;
   logic        hready, hresp;
   logic [31:0] hrdata;
   logic [15:0] err_cnt;

   int   vectors = 0;
   int   miscompares = 0;
   logic chk_on = 1'b0;

   always #5 clk = ~clk;

   scr1_tb_ahb_slave_mem #(
      .DATA_W(32), .ADDR_W(32), .MEM_BYTES(MEM_BYTES), .WAIT_W(4), .LFSR_SEED(16'hACE1)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_mode(cfg_mode), .cfg_wait(cfg_wait), .cfg_err_en(cfg_err_en),
      .cfg_err_lo(cfg_err_lo), .cfg_err_hi(cfg_err_hi),
      .htrans(htrans), .hsize(hsize), .haddr(haddr), .hwrite(hwrite), .hwdata(hwdata),
      .hready(hready), .hresp(hresp), .hrdata(hrdata), .err_cnt(err_cnt)
   );

   // Model: each accepted transfer expands into a list of expected bus cycles
   typedef struct {
      logic        rdy;
      logic        rsp;
      logic        fin;
      logic        wr;
      int unsigned a;
      int unsigned sz;
   } ent_t;

   ent_t        q[$];
   logic [7:0]  mb [MEM_BYTES];
   logic [15:0] m_lfsr = 16'hACE1;
   logic [15:0] m_errcnt = 16'd0;

   function automatic logic [31:0] mword(input int unsigned a);
      int unsigned b;
      b = a & ~32'd3;
      return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
   endfunction

   function automatic logic m_is_err(input int unsigned a, input int unsigned sz);
      if (a >= MEM_BYTES) return 1'b1;
      if (sz > 2) return 1'b1;
      if (a % (1 << sz) != 0) return 1'b1;
      if (cfg_err_en && a >= cfg_err_lo && a <= cfg_err_hi) return 1'b1;
      return 1'b0;
   endfunction

   initial begin : model
      ent_t        cur;
      int unsigned w;
      logic        e;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            q.delete();
            m_lfsr   = 16'hACE1;
            m_errcnt = 16'd0;
         end else begin
            if (q.size() != 0) cur = q.pop_front();
            else cur = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
            if (cur.fin && !cur.rsp && cur.wr)
               for (int i = 0; i < (1 << cur.sz); i++)
                  mb[cur.a + i] = hwdata[8*((cur.a + i) % 4) +: 8];
            if (cur.fin && cur.rsp && m_errcnt != 16'hFFFF) m_errcnt = m_errcnt + 16'd1;
            if (cur.rdy && htrans[1]) begin
               e = m_is_err(haddr, 32'(hsize));
               case (cfg_mode)
                  2'd1:    w = cfg_wait;
                  2'd2:    w = 32'(m_lfsr[3:0] & cfg_wait);
                  default: w = 0;
               endcase
               m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
               repeat (w) q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 0, 0});
               if (e) begin
                  q.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 0, 0});
                  q.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 0, 0});
               end else begin
                  q.push_back('{1'b1, 1'b0, 1'b1, hwrite, haddr, 32'(hsize)});
               end
            end
         end
      end
   end

   initial begin : compare
      logic        er, es;
      logic [31:0] ed;
      forever begin
         @(negedge clk);
         if (chk_on) begin
            er = 1'b1; es = 1'b0; ed = 32'd0;
            if (q.size() != 0) begin
               er = q[0].rdy;
               es = q[0].rsp;
               if (q[0].fin && !q[0].rsp) ed = mword(q[0].a);
            end
            vectors++;
            if ({hready, hresp, hrdata, err_cnt} !== {er, es, ed, m_errcnt}) begin
               miscompares++;
               $display("FAIL cycle @%0t: got rdy=%b resp=%b rdata=%h errcnt=%0d, need rdy=%b resp=%b rdata=%h errcnt=%0d",
                        $time, hready, hresp, hrdata, err_cnt, er, es, ed, m_errcnt);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, need %h", nm, act, exp);
      end
   endtask

   task automatic addr(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] wd);
      logic rdy;
      int   n;
      htrans = 2'b10; hwrite = wr; haddr = a; hsize = sz; n = 0;
      do begin
         @(negedge clk); rdy = hready;
         @(posedge clk); #2;
         n++;
      end while (!rdy && n < 200);
      if (!rdy) begin
         vectors++; miscompares++;
         $display("FAIL accept_timeout: hready got 0, need 1");
      end
      htrans = 2'b00;
      hwdata = wd;
   endtask

   task automatic wait_done(output int lows, output logic rsp, output logic [31:0] rd);
      logic rdy;
      lows = 0;
      do begin
         @(negedge clk);
         rdy = hready; rsp = hresp; rd = hrdata;
         if (!rdy) lows++;
      end while (!rdy && lows < 200);
      if (!rdy) begin
         vectors++; miscompares++;
         $display("FAIL done_timeout: hready got 0, need 1");
      end
      @(posedge clk); #2;
   endtask

   initial begin : global_limit
      #5ms;
      $display("FAIL global_timeout: bench did not reach its end");
      $fatal(1, "global timeout");
   end

   initial begin : stim
      int          lows;
      logic        rsp;
      logic [31:0] rd, a;
      logic [2:0]  sz;

      for (int i = 0; i < MEM_WORDS; i++) begin
         dut.mem[i] = {16'hC0DE, 16'(i)};
         mb[4*i]   = 8'(i);
         mb[4*i+1] = 8'(i >> 8);
         mb[4*i+2] = 8'hDE;
         mb[4*i+3] = 8'hC0;
      end

      repeat (3) @(posedge clk);
      #2;
      chk_on = 1'b1;
      chk("reset_hready", 32'(hready), 32'd1);
      chk("reset_hresp", 32'(hresp), 32'd0);
      chk("reset_hrdata", hrdata, 32'd0);
      chk("reset_errcnt", 32'(err_cnt), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #2;

      // Zero-wait pipelined write then read
      addr(1'b1, 32'h100, 3'd2, 32'hDEADBEEF);
      addr(1'b0, 32'h100, 3'd2, 32'h0);
      chk("b2b_rdata_now", hrdata, 32'hDEADBEEF);
      wait_done(lows, rsp, rd);
      chk("b2b_lows", 32'(lows), 32'd0);
      chk("b2b_rdata", rd, 32'hDEADBEEF);

      // Fixed waits
      cfg_mode = 2'd1; cfg_wait = 4'd3;
      addr(1'b0, 32'h200, 3'd2, 32'h0);
      wait_done(lows, rsp, rd);
      chk("fixed_lows", 32'(lows), 32'd3);
      chk("fixed_resp", 32'(rsp), 32'd0);
      chk("fixed_rdata", rd, 32'hC0DE0080);

      // Error window
      cfg_mode = 2'd0; cfg_err_en = 1'b1;
      addr(1'b1, 32'h1080, 3'd2, 32'h12345678);
      wait_done(lows, rsp, rd);
      chk("win_lows", 32'(lows), 32'd1);
      chk("win_resp", 32'(rsp), 32'd1);
      chk("win_errcnt", 32'(err_cnt), 32'd1);
      cfg_err_en = 1'b0;
      addr(1'b0, 32'h1080, 3'd2, 32'h0);
      wait_done(lows, rsp, rd);
      chk("win_readback", rd, 32'hC0DE0420);

      // Byte and halfword lanes
      addr(1'b1, 32'h300, 3'd2, 32'h11223344);
      addr(1'b1, 32'h302, 3'd0, 32'h77AA7777);
      addr(1'b1, 32'h300, 3'd1, 32'h99995566);
      addr(1'b0, 32'h300, 3'd2, 32'h0);
      wait_done(lows, rsp, rd);
      chk("lanes_rdata", rd, 32'h11AA5566);
      addr(1'b1, 32'h301, 3'd1, 32'hFFFFFFFF);
      wait_done(lows, rsp, rd);
      chk("misalign_resp", 32'(rsp), 32'd1);
      chk("misalign_errcnt", 32'(err_cnt), 32'd2);
      addr(1'b0, 32'h300, 3'd2, 32'h0);
      wait_done(lows, rsp, rd);
      chk("misalign_rdata", rd, 32'h11AA5566);

      // Reset in the middle of a write's wait phase
      cfg_mode = 2'd1; cfg_wait = 4'd5;
      addr(1'b1, 32'h400, 3'd2, 32'hCAFEF00D);
      chk("midwait_hready", 32'(hready), 32'd0);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_hready", 32'(hready), 32'd1);
      chk("async_rst_hresp", 32'(hresp), 32'd0);
      chk("async_rst_errcnt", 32'(err_cnt), 32'd0);
      @(posedge clk); #2;
      rst_n = 1'b1;

      // Random waits from a freshly seeded LFSR: 0xACE1, 0x59C3, 0xB387
      cfg_mode = 2'd2; cfg_wait = 4'hF;
      addr(1'b0, 32'h400, 3'd2, 32'h0);
      wait_done(lows, rsp, rd);
      chk("rnd0_lows", 32'(lows), 32'd1);
      chk("rst_word_kept", rd, 32'hC0DE0100);
      addr(1'b0, 32'h404, 3'd2, 32'h0);
      wait_done(lows, rsp, rd);
      chk("rnd1_lows", 32'(lows), 32'd3);
      addr(1'b0, 32'h408, 3'd2, 32'h0);
      wait_done(lows, rsp, rd);
      chk("rnd2_lows", 32'(lows), 32'd7);

      // Out-of-range read, then IDLE/BUSY cycles that must not advance the LFSR
      cfg_mode = 2'd0;
      addr(1'b0, 32'(MEM_BYTES), 3'd2, 32'h0);
      wait_done(lows, rsp, rd);
      chk("range_resp", 32'(rsp), 32'd1);
      chk("range_errcnt", 32'(err_cnt), 32'd1);
      for (int i = 0; i < 4; i++) begin
         htrans = (i % 2 == 1) ? 2'b01 : 2'b00;
         haddr  = 32'h500;
         @(negedge clk);
         chk("idle_hready", 32'(hready), 32'd1);
         chk("idle_hresp", 32'(hresp), 32'd0);
         @(posedge clk); #2;
      end
      htrans = 2'b00;
      cfg_mode = 2'd2; cfg_wait = 4'hF;
      addr(1'b0, 32'h40C, 3'd2, 32'h0);
      wait_done(lows, rsp, rd);
      chk("lfsr_after_idle_lows", 32'(lows), 32'd14);

      // Random traffic against the model
      for (int k = 0; k < 1000; k++) begin
         sz = ($urandom_range(0, 15) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
         a  = 32'($urandom_range(0, 255)) << 2;
         if (sz == 3'd0) a = a + 32'($urandom_range(0, 3));
         if (sz == 3'd1) a = a + 32'(2 * $urandom_range(0, 1));
         if ($urandom_range(0, 19) == 0) a = a + 32'($urandom_range(1, 3));
         if ($urandom_range(0, 49) == 0) a = 32'(MEM_BYTES) | (a & 32'hFF);
         if ($urandom_range(0, 3) == 0) begin
            htrans = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b00;
            @(posedge clk); #2;
         end
         addr(1'($urandom_range(0, 1)), a, sz, $urandom);
      end
      htrans = 2'b00;
      wait_done(lows, rsp, rd);
      repeat (3) @(posedge clk);
      #2;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
